oddr_serializer_ctrl: RTL and testbench

//  Sequences an ODDR output primitive. Accepts parallel words over a valid/ready handshake and

---
 rtl/oddr_serializer_ctrl.sv | 104 ++++++++++
 tb/tb_oddr_serializer_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/oddr_serializer_ctrl.sv
// rtl/oddr_serializer_ctrl.sv - word-to-pair serializer feeding an ODDR D1/D2/CE/R
module oddr_serializer_ctrl #(
    parameter int   DATA_WIDTH = 16,
    parameter bit   MSB_FIRST  = 1'b1,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENABLE,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    input  logic                  DATA_VALID,
    output logic                  DATA_READY,
    output logic                  ODDR_D1,
    output logic                  ODDR_D2,
    output logic                  ODDR_CE,
    output logic                  ODDR_R,
    output logic                  BUSY,
    output logic [15:0]           WORD_CNT
);

    localparam int NP = DATA_WIDTH / 2;
    localparam int PW = (NP > 1) ? $clog2(NP) : 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                  state_q, state_d;
    logic [PW-1:0]           pair_q, pair_d;
    logic [DATA_WIDTH-1:0]   shift_q, shift_d;
    logic                    d1_q, d1_d, d2_q, d2_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    r_q, ce_q;
    logic                    last, fire;

    always_comb begin
        state_d    = state_q;
        pair_d     = pair_q;
        shift_d    = shift_q;
        cnt_d      = cnt_q;
        d1_d       = IDLE_LEVEL;
        d2_d       = IDLE_LEVEL;
        last       = (pair_q == PW'(NP - 1));
        DATA_READY = ENABLE & ~RST & ((state_q == IDLE) | ((state_q == SHIFT) & last));
        fire       = DATA_VALID & DATA_READY;

        if (fire) begin
            state_d = SHIFT;
            pair_d  = '0;
            cnt_d   = cnt_q + 16'd1;
            // Pair 0 goes straight to the output flops; the rest waits in the shifter.
            if (MSB_FIRST) begin
                d1_d    = DATA_IN[DATA_WIDTH-1];
                d2_d    = DATA_IN[DATA_WIDTH-2];
                shift_d = DATA_IN << 2;
            end else begin
                d1_d    = DATA_IN[0];
                d2_d    = DATA_IN[1];
                shift_d = DATA_IN >> 2;
            end
        end else if (state_q == SHIFT && !last) begin
            pair_d = pair_q + PW'(1);
            if (MSB_FIRST) begin
                d1_d    = shift_q[DATA_WIDTH-1];
                d2_d    = shift_q[DATA_WIDTH-2];
                shift_d = shift_q << 2;
            end else begin
                d1_d    = shift_q[0];
                d2_d    = shift_q[1];
                shift_d = shift_q >> 2;
            end
        end else if (state_q == SHIFT) begin
            state_d = IDLE;
            pair_d  = '0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            pair_q  <= '0;
            shift_q <= '0;
            cnt_q   <= '0;
            d1_q    <= IDLE_LEVEL;
            d2_q    <= IDLE_LEVEL;
        end else begin
            state_q <= state_d;
            pair_q  <= pair_d;
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
            d1_q    <= d1_d;
            d2_q    <= d2_d;
        end
        // The ODDR is held in reset one cycle longer than the controller.
        r_q  <= RST;
        ce_q <= ~RST;
    end

    assign ODDR_D1  = d1_q;
    assign ODDR_D2  = d2_q;
    assign ODDR_R   = r_q;
    assign ODDR_CE  = ce_q;
    assign BUSY     = (state_q == SHIFT);
    assign WORD_CNT = cnt_q;

endmodule

// File: tb/tb_oddr_serializer_ctrl.sv
// tb/tb_oddr_serializer_ctrl.sv - directed bench for oddr_serializer_ctrl
module tb_oddr_serializer_ctrl;

    logic        clk = 1'b0;
    logic        rst, en, valid;
    logic [7:0]  data;
    logic        rst2, en2, valid2;
    logic [1:0]  data2;

    logic        m_ready, m_d1, m_d2, m_ce, m_r, m_busy;
    logic [15:0] m_cnt;
    logic        l_ready, l_d1, l_d2, l_ce, l_r, l_busy;
    logic [15:0] l_cnt;
    logic        s_ready, s_d1, s_d2, s_ce, s_r, s_busy;
    logic [15:0] s_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] pm = 8'b10_11_01_00;
    logic [7:0] pl = 8'b00_10_11_01;

    always #5 clk = ~clk;

    oddr_serializer_ctrl #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_m (
        .CLK(clk), .RST(rst), .ENABLE(en), .DATA_IN(data), .DATA_VALID(valid),
        .DATA_READY(m_ready), .ODDR_D1(m_d1), .ODDR_D2(m_d2), .ODDR_CE(m_ce),
        .ODDR_R(m_r), .BUSY(m_busy), .WORD_CNT(m_cnt));

    oddr_serializer_ctrl #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) u_l (
        .CLK(clk), .RST(rst), .ENABLE(en), .DATA_IN(data), .DATA_VALID(valid),
        .DATA_READY(l_ready), .ODDR_D1(l_d1), .ODDR_D2(l_d2), .ODDR_CE(l_ce),
        .ODDR_R(l_r), .BUSY(l_busy), .WORD_CNT(l_cnt));

    oddr_serializer_ctrl #(.DATA_WIDTH(2), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) u_s (
        .CLK(clk), .RST(rst2), .ENABLE(en2), .DATA_IN(data2), .DATA_VALID(valid2),
        .DATA_READY(s_ready), .ODDR_D1(s_d1), .ODDR_D2(s_d2), .ODDR_CE(s_ce),
        .ODDR_R(s_r), .BUSY(s_busy), .WORD_CNT(s_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; valid = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; valid = 1'b0; data = 8'h00;
        tick();
        n_cmp++;
        if ({m_r, m_ce, m_d1, m_d2, m_busy} !== 5'b10000) begin
            n_bad++; $display("FAIL reset_m r/ce/d1/d2/busy got %b want 10000", {m_r, m_ce, m_d1, m_d2, m_busy});
        end
        n_cmp++;
        if ({l_d1, l_d2, l_busy, m_cnt, l_cnt} !== {3'b110, 16'h0, 16'h0}) begin
            n_bad++; $display("FAIL reset_l d1/d2/busy/cnts got %b %h %h want 110 0 0", {l_d1, l_d2, l_busy}, m_cnt, l_cnt);
        end
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({m_r, m_ce} !== 2'b10) begin
            n_bad++; $display("FAIL release_delay r/ce got %b want 10", {m_r, m_ce});
        end
        tick();
        n_cmp++;
        if ({m_r, m_ce, l_r, l_ce, m_d1, m_d2} !== 6'b010100) begin
            n_bad++; $display("FAIL release r/ce/r/ce/d1/d2 got %b want 010100", {m_r, m_ce, l_r, l_ce, m_d1, m_d2});
        end
    endtask

    task automatic test_single();
        en = 1'b1; valid = 1'b1; data = 8'hB4;
        #1;
        n_cmp++;
        if ({m_ready, l_ready} !== 2'b11) begin
            n_bad++; $display("FAIL single_ready got %b want 11", {m_ready, l_ready});
        end
        tick();
        valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            n_cmp++;
            if ({m_d1, m_d2, m_busy} !== {pm[7-2*k], pm[6-2*k], 1'b1}) begin
                n_bad++; $display("FAIL single_msb pair %0d got %b want %b", k, {m_d1, m_d2, m_busy}, {pm[7-2*k], pm[6-2*k], 1'b1});
            end
            n_cmp++;
            if ({l_d1, l_d2, l_busy} !== {pl[7-2*k], pl[6-2*k], 1'b1}) begin
                n_bad++; $display("FAIL single_lsb pair %0d got %b want %b", k, {l_d1, l_d2, l_busy}, {pl[7-2*k], pl[6-2*k], 1'b1});
            end
            tick();
        end
        n_cmp++;
        if ({m_d1, m_d2, m_busy, l_d1, l_d2, l_busy} !== 6'b000110 || m_cnt !== 16'd1 || l_cnt !== 16'd1) begin
            n_bad++; $display("FAIL single_idle got %b cnt %0d/%0d want 000110 cnt 1/1", {m_d1, m_d2, m_busy, l_d1, l_d2, l_busy}, m_cnt, l_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        en = 1'b1; valid = 1'b1; data = 8'hFF;
        tick();
        data = 8'h00;
        for (int k = 0; k < 8; k++) begin
            #1;
            n_cmp++;
            if ({m_d1, m_d2, m_busy, m_ready} !== {(k < 4) ? 2'b11 : 2'b00, 1'b1, (k == 3 || k == 7)}) begin
                n_bad++; $display("FAIL b2b cycle %0d d1/d2/busy/ready got %b want %b", k, {m_d1, m_d2, m_busy, m_ready}, {(k < 4) ? 2'b11 : 2'b00, 1'b1, (k == 3 || k == 7)});
            end
            if (k == 4) valid = 1'b0;
            tick();
        end
        n_cmp++;
        if (m_busy !== 1'b0 || m_cnt !== 16'd2) begin
            n_bad++; $display("FAIL b2b_end busy %b cnt %0d want 0 2", m_busy, m_cnt);
        end
    endtask

    task automatic test_enable_drop();
        en = 1'b1; valid = 1'b1; data = 8'hB4;
        tick();
        data = 8'hFF;
        tick();
        en = 1'b0;
        for (int k = 1; k < 4; k++) begin
            #1;
            n_cmp++;
            if ({m_d1, m_d2, m_busy, m_ready} !== {pm[7-2*k], pm[6-2*k], 2'b10}) begin
                n_bad++; $display("FAIL en_drop pair %0d got %b want %b", k, {m_d1, m_d2, m_busy, m_ready}, {pm[7-2*k], pm[6-2*k], 2'b10});
            end
            tick();
        end
        tick();
        #1;
        n_cmp++;
        if ({m_busy, m_ready, m_d1} !== 3'b000 || m_cnt !== 16'd3) begin
            n_bad++; $display("FAIL en_hold busy/ready/d1 %b cnt %0d want 000 3", {m_busy, m_ready, m_d1}, m_cnt);
        end
        en = 1'b1;
        #1;
        n_cmp++;
        if (m_ready !== 1'b1) begin
            n_bad++; $display("FAIL en_resume_ready got %b want 1", m_ready);
        end
        tick();
        valid = 1'b0;
        n_cmp++;
        if ({m_d1, m_d2, m_busy} !== 3'b111 || m_cnt !== 16'd4) begin
            n_bad++; $display("FAIL en_resume got %b cnt %0d want 111 4", {m_d1, m_d2, m_busy}, m_cnt);
        end
        repeat (4) tick();
    endtask

    task automatic test_reset_mid();
        en = 1'b1; valid = 1'b1; data = 8'hB4;
        tick();
        valid = 1'b0;
        tick();
        tick();
        n_cmp++;
        if ({m_d1, m_d2, m_busy} !== 3'b011) begin
            n_bad++; $display("FAIL rst_mid_pre pair2 got %b want 011", {m_d1, m_d2, m_busy});
        end
        rst = 1'b1; valid = 1'b1;
        #1;
        n_cmp++;
        if ({m_ready, l_ready} !== 2'b00) begin
            n_bad++; $display("FAIL rst_mid_ready got %b want 00", {m_ready, l_ready});
        end
        tick();
        n_cmp++;
        if ({m_d1, m_d2, m_busy, m_r, m_ce, l_d1, l_d2} !== 7'b0001011 || m_cnt !== 16'd0) begin
            n_bad++; $display("FAIL rst_mid got %b cnt %0d want 0001011 0", {m_d1, m_d2, m_busy, m_r, m_ce, l_d1, l_d2}, m_cnt);
        end
        rst = 1'b0; valid = 1'b0;
        tick();
    endtask

    task automatic test_wrap();
        rst2 = 1'b0; en2 = 1'b1; valid2 = 1'b1; data2 = 2'b10;
        repeat (65535) tick();
        n_cmp++;
        if (s_cnt !== 16'hFFFF || {s_d1, s_d2, s_busy, s_ready} !== 4'b1011) begin
            n_bad++; $display("FAIL w2_full cnt %h d1/d2/busy/ready %b want ffff 1011", s_cnt, {s_d1, s_d2, s_busy, s_ready});
        end
        data2 = 2'b01;
        tick();
        valid2 = 1'b0;
        n_cmp++;
        if (s_cnt !== 16'h0000 || {s_d1, s_d2} !== 2'b01) begin
            n_bad++; $display("FAIL w2_wrap cnt %h d1/d2 %b want 0000 01", s_cnt, {s_d1, s_d2});
        end
        tick();
        n_cmp++;
        if ({s_busy, s_d1, s_d2} !== 3'b000 || s_cnt !== 16'h0000) begin
            n_bad++; $display("FAIL w2_idle got %b cnt %h want 000 0000", {s_busy, s_d1, s_d2}, s_cnt);
        end
    endtask

    initial begin
        rst2 = 1'b1; en2 = 1'b0; valid2 = 1'b0; data2 = 2'b00;
        test_reset();
        test_single();
        test_back_to_back();
        test_enable_drop();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
